// File: rtl/rx_frame_buffer_pkg.sv
// Shared types for the receive frame buffer: the stored AXIS beat and the write-side FSM states.
package rx_frame_buffer_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEEP_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } axis_beat_t;

  localparam int unsigned BEAT_W = $bits(axis_beat_t);

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_FRAME = 2'd1,
    WR_DROP  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/rx_frame_buffer_if.sv
// AXI-stream bundle used for both the MAC-side input and the committed-frame output.
interface rx_frame_buffer_if;
  import rx_frame_buffer_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tlast;
  logic              tuser;
  logic              tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/rx_frame_buffer_sdp_ram.sv
// Simple dual-port RAM, single clock, registered read port that holds its value when not read.
module sdp_ram #(
  parameter int unsigned WIDTH = 73,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write and registered read; no reset so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/rx_frame_buffer.sv
// Store-and-forward receive buffer: frames are written speculatively and only become readable
// once their last beat arrives good; bad or overflowing frames are rolled back and counted.
module rx_frame_buffer
  import rx_frame_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  rx_frame_buffer_if.slave  s00_axis,
  rx_frame_buffer_if.master m00_axis,
  output logic [CNT_W-1:0] o_drop_count,
  output logic [CNT_W-1:0] o_frame_count,
  output logic             o_overflow
);

  localparam int unsigned     AW       = $clog2(DEPTH);
  localparam logic [AW:0]     PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]     PTR_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return v;
    else return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  wr_state_t        state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
  // rd_ptr frees slots only when a beat leaves the output register; fetch_ptr runs ahead into the pipeline.
  logic [AW:0]      rd_ptr_q, rd_ptr_d, fetch_ptr_q, fetch_ptr_d;
  logic [CNT_W-1:0] drop_q, drop_d, frame_q, frame_d;
  logic             ovf_q, ovf_d;
  logic             ram_valid_q, ram_valid_d, out_valid_q, out_valid_d;
  axis_beat_t       out_q, out_d, wr_beat_s, ram_rdata_s;
  logic             full_s, wr_en_s, avail_s, out_ready_s, load_s, issue_s, xfer_s;

  assign wr_beat_s = '{data: s00_axis.tdata, keep: s00_axis.tkeep, last: s00_axis.tlast};
  assign full_s    = ((wr_ptr_q - rd_ptr_q) == PTR_FULL);

  // Write-side FSM: speculative write, commit on good tlast, rollback on error or overflow.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    drop_d       = drop_q;
    frame_d      = frame_q;
    ovf_d        = 1'b0;
    wr_en_s      = 1'b0;
    case (state_q)
      WR_IDLE, WR_FRAME: begin
        if (s00_axis.tvalid) begin
          if (full_s) begin
            ovf_d    = 1'b1;
            wr_ptr_d = commit_ptr_q;
            drop_d   = sat_inc(drop_q);
            state_d  = s00_axis.tlast ? WR_IDLE : WR_DROP;
          end else if (s00_axis.tlast && s00_axis.tuser) begin
            wr_ptr_d = commit_ptr_q;
            drop_d   = sat_inc(drop_q);
            state_d  = WR_IDLE;
          end else begin
            wr_en_s  = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (s00_axis.tlast) begin
              commit_ptr_d = wr_ptr_q + PTR_ONE;
              frame_d      = sat_inc(frame_q);
              state_d      = WR_IDLE;
            end else begin
              state_d = WR_FRAME;
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      WR_DROP: begin
        if (s00_axis.tvalid && s00_axis.tlast) begin
          state_d = WR_IDLE;
        end else begin
          state_d = WR_DROP;
        end
      end
      default: begin
        state_d = WR_IDLE;
      end
    endcase
  end

  // Read side: RAM output stage feeding a skid output register, one beat per cycle when ready.
  always_comb begin
    avail_s     = (fetch_ptr_q != commit_ptr_q);
    out_ready_s = !out_valid_q || m00_axis.tready;
    load_s      = ram_valid_q && out_ready_s;
    issue_s     = avail_s && (!ram_valid_q || out_ready_s);
    xfer_s      = out_valid_q && m00_axis.tready;
    fetch_ptr_d = issue_s ? (fetch_ptr_q + PTR_ONE) : fetch_ptr_q;
    rd_ptr_d    = xfer_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    if (issue_s) begin
      ram_valid_d = 1'b1;
    end else if (load_s) begin
      ram_valid_d = 1'b0;
    end else begin
      ram_valid_d = ram_valid_q;
    end
    if (load_s) begin
      out_valid_d = 1'b1;
      out_d       = ram_rdata_s;
    end else if (xfer_s) begin
      out_valid_d = 1'b0;
      out_d       = out_q;
    end else begin
      out_valid_d = out_valid_q;
      out_d       = out_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q      <= WR_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      drop_q       <= '0;
      frame_q      <= '0;
      ovf_q        <= 1'b0;
      ram_valid_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      drop_q       <= drop_d;
      frame_q      <= frame_d;
      ovf_q        <= ovf_d;
      ram_valid_q  <= ram_valid_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
    end
  end

  sdp_ram #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i     (i_clk),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (wr_beat_s),
    .rd_en_i   (issue_s),
    .rd_addr_i (fetch_ptr_q[AW-1:0]),
    .rd_data_o (ram_rdata_s)
  );

  assign s00_axis.tready = 1'b1;
  assign m00_axis.tdata  = out_q.data;
  assign m00_axis.tkeep  = out_q.keep;
  assign m00_axis.tlast  = out_q.last;
  assign m00_axis.tvalid = out_valid_q;
  assign m00_axis.tuser  = 1'b0;
  assign o_drop_count    = drop_q;
  assign o_frame_count   = frame_q;
  assign o_overflow      = ovf_q;

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Randomised bench for rx_frame_buffer against a queue-based frame scoreboard.
module tb_rx_frame_buffer;

  localparam int DEPTH = 64;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_frame_buffer_if s_if();
  rx_frame_buffer_if m_if();
  logic [CNT_W-1:0] drop_cnt, frame_cnt;
  logic             ovf;

  rx_frame_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .s00_axis      (s_if),
    .m00_axis      (m_if),
    .o_drop_count  (drop_cnt),
    .o_frame_count (frame_cnt),
    .o_overflow    (ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [72:0] got, input logic [72:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: committed beats awaiting output, beats of the frame in progress.
  logic [72:0] exp_q[$];
  logic [72:0] pend_q[$];
  bit          dropping, m_ovf, mon_on, rst_prev, prev_v, prev_r;
  int          m_drops, m_frames, xfer_cnt, ovf_cnt, ready_mode;
  logic [72:0] prev_beat;

  // Downstream ready: 0 = stalled, 1 = always ready, 2 = random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_if.tready = 1'b0;
      1:       m_if.tready = 1'b1;
      default: m_if.tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: check registered outputs, then advance the model with the beat about to be sampled.
  always @(negedge clk) begin
    logic [72:0] out_beat, in_beat;
    out_beat = {m_if.tdata, m_if.tkeep, m_if.tlast};
    in_beat  = {s_if.tdata, s_if.tkeep, s_if.tlast};
    if (mon_on) begin
      check_value("overflow", 73'(ovf), 73'(m_ovf));
      check_value("drop_count", 73'(drop_cnt), 73'(m_drops));
      check_value("frame_count", 73'(frame_cnt), 73'(m_frames));
      if (ovf === 1'b1) ovf_cnt++;
      if (rst_prev) begin
        check_value("reset_tvalid", 73'(m_if.tvalid), 73'(0));
        check_value("reset_tdata", out_beat, 73'(0));
      end
      if (prev_v && !prev_r) begin
        check_value("hold_tvalid", 73'(m_if.tvalid), 73'(1));
        check_value("hold_beat", out_beat, prev_beat);
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      pend_q.delete();
      dropping = 1'b0;
      m_ovf    = 1'b0;
      m_drops  = 0;
      m_frames = 0;
      mon_on   = 1'b1;
      rst_prev = 1'b1;
      prev_v   = 1'b0;
      prev_r   = 1'b0;
    end else begin
      rst_prev = 1'b0;
      m_ovf    = 1'b0;
      if (s_if.tvalid) begin
        if (dropping) begin
          if (s_if.tlast) dropping = 1'b0;
        end else if (exp_q.size() + pend_q.size() >= DEPTH) begin
          m_ovf = 1'b1;
          m_drops++;
          pend_q.delete();
          dropping = !s_if.tlast;
        end else if (s_if.tlast && s_if.tuser) begin
          m_drops++;
          pend_q.delete();
        end else begin
          pend_q.push_back(in_beat);
          if (s_if.tlast) begin
            foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
            pend_q.delete();
            m_frames++;
          end
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        xfer_cnt++;
        check_value("sb_has_beat", 73'(exp_q.size() != 0), 73'(1));
        if (exp_q.size() != 0) check_value("out_beat", out_beat, exp_q.pop_front());
      end
      prev_v    = m_if.tvalid;
      prev_r    = m_if.tready;
      prev_beat = out_beat;
    end
  end

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic send_beats(input int len, input bit with_last, input bit bad, input logic [7:0] last_keep);
    for (int i = 0; i < len; i++) begin
      bit is_last;
      @(posedge clk);
      #1;
      is_last       = with_last && (i == len - 1);
      s_if.tvalid   = 1'b1;
      s_if.tdata    = {$urandom(), $urandom()};
      s_if.tlast    = is_last;
      s_if.tkeep    = is_last ? last_keep : 8'hFF;
      s_if.tuser    = is_last ? bad : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
    end
  endtask

  task automatic drain();
    idle(2);
    ready_mode = 1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) wait_neg();
    check_value("drain_empty", 73'(exp_q.size()), 73'(0));
  endtask

  int x0, o0;

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    ready_mode  = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_neg();
    check_value("rst_tvalid", 73'(m_if.tvalid), 73'(0));
    check_value("rst_drops", 73'(drop_cnt), 73'(0));
    check_value("rst_frames", 73'(frame_cnt), 73'(0));
    check_value("rst_ovf", 73'(ovf), 73'(0));

    // Good 8-beat frame: latency and sustained throughput.
    x0 = xfer_cnt;
    send_beats(8, 1'b1, 1'b0, 8'hFF);
    @(posedge clk);
    #1 s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
    wait_neg();
    check_value("lat_n0", 73'(m_if.tvalid), 73'(0));
    wait_neg();
    check_value("lat_n1", 73'(m_if.tvalid), 73'(0));
    wait_neg();
    check_value("lat_n2", 73'(m_if.tvalid), 73'(1));
    repeat (7) wait_neg();
    check_value("thru_8", 73'(xfer_cnt - x0), 73'(8));
    drain();
    check_value("t1_frames", 73'(frame_cnt), 73'(1));

    // Bad frame followed by a good one.
    x0 = xfer_cnt;
    send_beats(5, 1'b1, 1'b1, 8'hFF);
    send_beats(3, 1'b1, 1'b0, 8'h07);
    drain();
    check_value("t2_beats", 73'(xfer_cnt - x0), 73'(3));
    check_value("t2_drops", 73'(drop_cnt), 73'(1));
    check_value("t2_frames", 73'(frame_cnt), 73'(2));

    // Fill the buffer exactly with tready low; the fifth frame overflows on its first beat.
    ready_mode = 0;
    x0 = xfer_cnt;
    o0 = ovf_cnt;
    repeat (4) send_beats(16, 1'b1, 1'b0, 8'hFF);
    send_beats(4, 1'b1, 1'b0, 8'h01);
    idle(3);
    wait_neg();
    check_value("t3_ovf_pulses", 73'(ovf_cnt - o0), 73'(1));
    check_value("t3_drops", 73'(drop_cnt), 73'(2));
    check_value("t3_frames", 73'(frame_cnt), 73'(6));
    drain();
    check_value("t3_beats", 73'(xfer_cnt - x0), 73'(64));

    // Frame longer than the buffer, then a short frame.
    x0 = xfer_cnt;
    o0 = ovf_cnt;
    send_beats(70, 1'b1, 1'b0, 8'hFF);
    send_beats(2, 1'b1, 1'b0, 8'h3F);
    drain();
    check_value("t4_beats", 73'(xfer_cnt - x0), 73'(2));
    check_value("t4_ovf_pulses", 73'(ovf_cnt - o0), 73'(1));
    check_value("t4_drops", 73'(drop_cnt), 73'(3));
    check_value("t4_frames", 73'(frame_cnt), 73'(7));

    // Random back-to-back frames against random backpressure.
    ready_mode = 2;
    repeat (40) begin
      send_beats($urandom_range(1, 20), 1'b1, ($urandom_range(0, 4) == 0),
                 8'hFF >> 3'($urandom_range(0, 7)));
      idle($urandom_range(0, 2));
    end
    drain();

    // Reset mid-frame with two frames buffered; the tail after release is a new frame.
    ready_mode = 0;
    send_beats(3, 1'b1, 1'b0, 8'hFF);
    send_beats(3, 1'b1, 1'b0, 8'hFF);
    send_beats(4, 1'b0, 1'b0, 8'hFF);
    @(posedge clk);
    #1 rst_n = 1'b0;
    s_if.tdata = {$urandom(), $urandom()};
    @(posedge clk);
    #1 rst_n = 1'b1;
    s_if.tdata = {$urandom(), $urandom()};
    s_if.tlast = 1'b0;
    wait_neg();
    check_value("t6_tvalid", 73'(m_if.tvalid), 73'(0));
    check_value("t6_drops", 73'(drop_cnt), 73'(0));
    check_value("t6_frames", 73'(frame_cnt), 73'(0));
    x0 = xfer_cnt;
    send_beats(1, 1'b1, 1'b0, 8'h0F);
    drain();
    check_value("t6_beats", 73'(xfer_cnt - x0), 73'(2));
    check_value("t6_frames_after", 73'(frame_cnt), 73'(1));

    idle(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
